// File: rtl/en_passant_stream.sv
`default_nettype none
// ============================================================================
// Module   : en_passant_stream
// Purpose  : Captures en-passant flags and rank snapshots on start, then
//            streams each legal capture as a 16-bit move over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module en_passant_stream #(
  parameter int         COLS  = 8,
  parameter logic       WHITE = 1'b0,
  parameter logic       BLACK = 1'b1,
  parameter logic [2:0] PAWN  = 3'd1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                side_i,
  input  logic [2*COLS-1:0]   enp_flags_i,
  input  logic [10*COLS-1:0]  row_4_i,
  input  logic [10*COLS-1:0]  row_5_i,
  output logic                busy_o,
  output logic                move_valid_o,
  input  logic                move_ready_i,
  output logic [15:0]         move_data_o,
  output logic                done_o,
  output logic [1:0]          move_count_o,
  output logic                flag_err_o
);

  if (COLS < 2 || COLS > 8) begin : g_cols_check
    $error("en_passant_stream: COLS must be in 2..8");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    pend_q, pend_d;
  logic [15:0]   mv_l_q, mv_l_d;
  logic [15:0]   mv_r_q, mv_r_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [4:0]         w_nflags;
  logic [2:0]         w_t;
  logic               w_r5;
  logic               w_att;
  logic               w_ok;
  logic [10*COLS-1:0] w_row;
  logic [9:0]         w_pl, w_pr;
  logic               w_hit_l, w_hit_r;
  logic [2:0]         w_src_row, w_dst_row;
  logic [15:0]        w_mv_l, w_mv_r;

  // Flag decode: the last set bit wins for t/rank, but only a count of one is honoured.
  always_comb begin : decode
    w_nflags = '0;
    w_t      = '0;
    w_r5     = 1'b0;
    for (int i = 0; i < COLS; i++) begin
      if (enp_flags_i[2*COLS-1-i]) begin
        w_nflags = w_nflags + 5'd1;
        w_t      = 3'(i);
        w_r5     = 1'b0;
      end
      if (enp_flags_i[COLS-1-i]) begin
        w_nflags = w_nflags + 5'd1;
        w_t      = 3'(i);
        w_r5     = 1'b1;
      end
    end

    w_row = w_r5 ? row_5_i : row_4_i;
    w_att = w_r5 ? WHITE : BLACK;
    w_ok  = (w_nflags == 5'd1) && (side_i == w_att);

    w_pl = '0;
    w_pr = '0;
    for (int c = 0; c < COLS; c++) begin
      if (c + 1 == int'(w_t)) w_pl = w_row[10*c +: 10];
      if (c == int'(w_t) + 1) w_pr = w_row[10*c +: 10];
    end

    w_hit_l = w_ok && (w_t != 3'd0) &&
              (w_pl[9:7] == PAWN) && (w_pl[0] == w_att);
    w_hit_r = w_ok && (int'(w_t) < COLS - 1) &&
              (w_pr[9:7] == PAWN) && (w_pr[0] == w_att);

    w_src_row = w_r5 ? 3'd4 : 3'd3;
    w_dst_row = w_r5 ? 3'd5 : 3'd2;
    w_mv_l    = {4'b0001, w_t - 3'd1, w_src_row, w_t, w_dst_row};
    w_mv_r    = {4'b0001, w_t + 3'd1, w_src_row, w_t, w_dst_row};
  end

  always_comb begin : next_state
    state_d = state_q;
    pend_d  = pend_q;
    mv_l_d  = mv_l_q;
    mv_r_d  = mv_r_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          pend_d  = {w_hit_r, w_hit_l};
          mv_l_d  = w_mv_l;
          mv_r_d  = w_mv_r;
          cnt_d   = 2'd0;
          err_d   = (w_nflags > 5'd1);
          state_d = (w_hit_l || w_hit_r) ? S_EMIT : S_DONE;
        end
      end
      S_EMIT: begin
        if (move_ready_i) begin
          if (pend_q[0]) pend_d[0] = 1'b0;
          else           pend_d[1] = 1'b0;
          cnt_d = cnt_q + 2'd1;
          if (pend_d == 2'b00) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      mv_l_q  <= '0;
      mv_r_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mv_l_q  <= mv_l_d;
      mv_r_q  <= mv_r_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign move_valid_o = (state_q == S_EMIT);
  assign move_data_o  = move_valid_o ? (pend_q[0] ? mv_l_q : mv_r_q) : 16'h0000;
  assign done_o       = (state_q == S_DONE);
  assign move_count_o = cnt_q;
  assign flag_err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_en_passant_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_en_passant_stream
// Purpose  : Randomised and directed checks of en_passant_stream (COLS=8 and 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_en_passant_stream;
  localparam logic       WHITE = 1'b0;
  localparam logic       BLACK = 1'b1;
  localparam logic [2:0] PAWN  = 3'd1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sel4 = 1'b0;
  logic        side = 1'b0;
  logic [15:0] flags = '0;
  logic [79:0] r4 = '0;
  logic [79:0] r5 = '0;
  logic        ready = 1'b0;

  logic        b8, v8, d8, e8, b4, v4, d4, e4;
  logic [15:0] m8, m4;
  logic [1:0]  c8, c4;
  logic        busy, valid, done, ferr;
  logic [15:0] data;
  logic [1:0]  cnt;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  logic        exp_err;

  always #5 clk = ~clk;

  en_passant_stream #(.COLS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start & ~sel4), .side_i(side),
    .enp_flags_i(flags), .row_4_i(r4), .row_5_i(r5),
    .busy_o(b8), .move_valid_o(v8), .move_ready_i(ready), .move_data_o(m8),
    .done_o(d8), .move_count_o(c8), .flag_err_o(e8)
  );

  en_passant_stream #(.COLS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(start & sel4), .side_i(side),
    .enp_flags_i(flags[7:0]), .row_4_i(r4[39:0]), .row_5_i(r5[39:0]),
    .busy_o(b4), .move_valid_o(v4), .move_ready_i(ready), .move_data_o(m4),
    .done_o(d4), .move_count_o(c4), .flag_err_o(e4)
  );

  assign busy  = sel4 ? b4 : b8;
  assign valid = sel4 ? v4 : v8;
  assign data  = sel4 ? m4 : m8;
  assign done  = sel4 ? d4 : d8;
  assign cnt   = sel4 ? c4 : c8;
  assign ferr  = sel4 ? e4 : e8;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [9:0] piece(input logic [2:0] ty, input int c, input int r, input logic col);
    return {ty, 3'(c), 3'(r), col};
  endfunction

  function automatic logic [79:0] put(input logic [79:0] row, input int c, input logic [9:0] p);
    logic [79:0] o;
    o = row;
    o[10*c +: 10] = p;
    return o;
  endfunction

  // Reference: list every flagged square, then look left/right of a lone target for an enemy pawn.
  function automatic void model(input int C, input logic s, input logic [15:0] f,
                                input logic [79:0] a4, input logic [79:0] a5);
    int hr[$];
    int hf[$];
    int rank, t, c;
    logic att;
    logic [9:0] p;
    exp_q.delete();
    exp_err = 1'b0;
    for (int rk = 4; rk <= 5; rk++)
      for (int fl = 0; fl < C; fl++)
        if (f[(rk == 4) ? 2*C-1-fl : C-1-fl]) begin
          hr.push_back(rk);
          hf.push_back(fl);
        end
    if (hr.size() > 1) begin
      exp_err = 1'b1;
      return;
    end
    if (hr.size() == 0) return;
    rank = hr[0];
    t    = hf[0];
    att  = (rank == 4) ? BLACK : WHITE;
    if (s != att) return;
    for (int d = -1; d <= 1; d += 2) begin
      c = t + d;
      if (c < 0 || c >= C) continue;
      p = (rank == 4) ? a4[10*c +: 10] : a5[10*c +: 10];
      if (p[9:7] == PAWN && p[0] == att)
        exp_q.push_back({4'b0001, 3'(c), 3'(rank - 1), 3'(t), 3'((rank == 4) ? 2 : 5)});
    end
  endfunction

  task automatic run_job(input bit use4, input logic s, input logic [15:0] f,
                         input logic [79:0] a4, input logic [79:0] a5,
                         input int hold, input bit rnd, input bit restart, input string tag);
    int idx, stalls, done_cyc;
    bit was_stall;
    logic [15:0] last;
    sel4 = use4;
    model(use4 ? 4 : 8, s, f, a4, a5);
    @(negedge clk);
    side = s; flags = f; r4 = a4; r5 = a5;
    ready = (hold == 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    side  = 1'($urandom);
    flags = 16'($urandom);
    r4    = {16'($urandom), $urandom, $urandom};
    r5    = {16'($urandom), $urandom, $urandom};
    idx = 0; stalls = 0; done_cyc = -1; was_stall = 0; last = '0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      check({tag, "/busy"}, busy, 1);
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (valid) begin
        if (idx < exp_q.size()) check({tag, "/data"}, data, exp_q[idx]);
        else                    check({tag, "/extra_valid"}, valid, 0);
        if (was_stall) check({tag, "/stable"}, data, last);
        last = data;
        if (stalls < hold) ready = 1'b0;
        else if (rnd)      ready = 1'($urandom);
        else               ready = 1'b1;
        if (ready) begin
          idx++;
          was_stall = 0;
        end else begin
          stalls++;
          was_stall = 1;
        end
        if (restart && cyc == 2) start = 1'b1;
      end else begin
        check({tag, "/data_idle"}, data, 0);
      end
    end
    start = 1'b0;
    if (done_cyc < 0) check({tag, "/timeout"}, done, 1);
    check({tag, "/count"}, cnt, exp_q.size());
    check({tag, "/flag_err"}, ferr, exp_err);
    check({tag, "/transfers"}, idx, exp_q.size());
    check({tag, "/latency"}, done_cyc, exp_q.size() + 1 + stalls);
    @(negedge clk);
    check({tag, "/idle_busy"}, busy, 0);
    check({tag, "/idle_done"}, done, 0);
    if (restart) begin
      @(negedge clk);
      check({tag, "/no_requeue"}, busy, 0);
    end
  endtask

  initial begin
    logic [79:0] a4, a5;
    logic [15:0] f;
    logic s;
    bit u4;
    int C, mode, rk, fl, b1, b2, hold;

    #12;
    check("reset/busy", busy, 0);
    check("reset/valid", valid, 0);
    check("reset/data", data, 0);
    check("reset/done", done, 0);
    check("reset/count", cnt, 0);
    check("reset/flag_err", ferr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    a4 = put(put('0, 0, piece(PAWN, 0, 3, BLACK)), 2, piece(PAWN, 2, 3, BLACK));
    run_job(0, BLACK, 16'h4000, a4, '0, 0, 0, 0, "b4_two");

    a4 = put(put('0, 1, piece(PAWN, 1, 3, BLACK)), 7, piece(PAWN, 7, 3, BLACK));
    run_job(0, BLACK, 16'h8000, a4, '0, 0, 0, 0, "a4_edge");

    a5 = put(put('0, 6, piece(PAWN, 6, 4, WHITE)), 5, piece(PAWN, 5, 4, WHITE));
    run_job(0, WHITE, 16'h0001, '0, a5, 5, 0, 0, "h5_stall");

    a4 = put('0, 4, piece(PAWN, 4, 3, BLACK));
    a5 = put('0, 2, piece(PAWN, 2, 4, WHITE));
    run_job(0, BLACK, 16'h0410, a4, a5, 0, 0, 0, "multi_flag");

    a4 = put(put('0, 3, piece(PAWN, 3, 3, BLACK)), 5, piece(PAWN, 5, 3, BLACK));
    run_job(0, WHITE, 16'h0800, a4, '0, 0, 0, 0, "side_mismatch");

    a4 = put(put('0, 0, piece(PAWN, 0, 3, BLACK)), 2, piece(PAWN, 2, 3, BLACK));
    sel4 = 1'b0;
    @(negedge clk);
    side = BLACK; flags = 16'h4000; r4 = a4; r5 = '0; ready = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("rst_mid/valid_before", valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid/busy", busy, 0);
    check("rst_mid/valid", valid, 0);
    check("rst_mid/data", data, 0);
    check("rst_mid/done", done, 0);
    check("rst_mid/count", cnt, 0);
    check("rst_mid/flag_err", ferr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(0, BLACK, 16'h4000, a4, '0, 0, 0, 0, "after_reset");

    a5 = put('0, 2, piece(PAWN, 2, 4, WHITE));
    run_job(1, WHITE, 16'h0001, '0, a5, 3, 0, 1, "cols4_restart");

    for (int j = 0; j < 40; j++) begin
      u4 = (j % 5 == 4);
      C  = u4 ? 4 : 8;
      f  = '0;
      mode = $urandom_range(0, 9);
      rk = $urandom_range(4, 5);
      if (mode < 7) begin
        fl = $urandom_range(0, C - 1);
        f[(rk == 4) ? 2*C-1-fl : C-1-fl] = 1'b1;
      end else if (mode < 9) begin
        b1 = $urandom_range(0, 2*C - 1);
        b2 = (b1 + $urandom_range(1, 2*C - 1)) % (2*C);
        f[b1] = 1'b1;
        f[b2] = 1'b1;
      end
      a4 = '0;
      a5 = '0;
      for (int c = 0; c < C; c++) begin
        a4 = put(a4, c, piece(($urandom_range(0, 2) == 0) ? 3'($urandom) : PAWN, c, 3, 1'($urandom)));
        a5 = put(a5, c, piece(($urandom_range(0, 2) == 0) ? 3'($urandom) : PAWN, c, 4, 1'($urandom)));
      end
      if ($urandom_range(0, 3) != 0) s = (rk == 4) ? BLACK : WHITE;
      else                          s = 1'($urandom);
      hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      run_job(u4, s, f, a4, a5, hold, 1'($urandom), 0, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
